// File: rtl/p_mul_pkg.sv
// p_mul_pkg: shared types, pack-width indices and helpers for the packed radix multiplier
package p_mul_pkg;
  localparam int PW_IDX_FULL = 0;
  localparam int PW_IDX_HALF = 1;
  localparam int PW_IDX_QUARTER = 2;
  localparam int PW_IDX_EIGHTH = 3;
  localparam int PW_IDX_SIXTEENTH = 4;
  localparam int PW_IDX_THIRTYSECOND = 5;
  typedef enum logic [1:0] {IDLE, RUN, DONE} p_mul_state_t;
  function automatic int p_mul_steps(input int xlen, input int k, input int bps);
    return ((xlen >> k) + bps - 1) / bps;
  endfunction
  function automatic bit p_mul_xlen_ok(input int xlen);
    return xlen == 32 || xlen == 64;
  endfunction
  function automatic bit p_mul_bps_ok(input int bps);
    return bps == 1 || bps == 2 || bps == 4;
  endfunction
endpackage

// File: rtl/p_mul_step.sv
// p_mul_step: one accumulation step retiring up to BPS multiplier bits in every packed lane
module p_mul_step
  import p_mul_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int BPS = 1,
  parameter int PWW = $clog2(XLEN)
) (
  input  logic [2*XLEN-1:0] i_acc,
  input  logic [2*XLEN-1:0] i_mcand,
  input  logic [XLEN-1:0]   i_mplier,
  input  logic [PWW-1:0]    i_pw,
  input  logic              i_clmul,
  output logic [2*XLEN-1:0] o_acc
);
  logic [PWW-1:0][2*XLEN-1:0] w_nxt;
  logic w_unused;
  assign w_unused = ^i_mplier;
  for (genvar k = 0; k < PWW; k++) begin : g_k
    localparam int W = XLEN >> k;
    localparam int B = BPS < W ? BPS : W;
    logic [2*XLEN-1:0] w_n;
    logic [2*W-1:0] w_m, w_p;
    // multiplicand and multiplier arrive pre-shifted, so each lane reads its bits at offset 0
    always_comb begin
      w_n = '0;
      w_m = '0;
      w_p = '0;
      for (int i = 0; i < XLEN / W; i++) begin
        w_m = i_mcand[2*W*i +: 2*W];
        w_p = '0;
        for (int j = 0; j < B; j++)
          if (i_mplier[W*i+j]) w_p = i_clmul ? w_p ^ (w_m << j) : w_p + (w_m << j);
        w_n[2*W*i +: 2*W] = i_clmul ? i_acc[2*W*i +: 2*W] ^ w_p : i_acc[2*W*i +: 2*W] + w_p;
      end
    end
    assign w_nxt[k] = w_n;
  end
  always_comb begin
    o_acc = i_acc;
    for (int k = 0; k < PWW; k++)
      if (i_pw == (PWW'(1) << k)) o_acc = w_nxt[k];
  end
endmodule

// File: rtl/p_mul_radix.sv
// p_mul_radix: multi-cycle packed integer/carry-less multiplier retiring BPS multiplier bits per step
module p_mul_radix
  import p_mul_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int BPS = 1,
  parameter int PWW = $clog2(XLEN)
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            valid,
  output logic            ready,
  input  logic            mul_l,
  input  logic            mul_h,
  input  logic            clmul,
  input  logic [PWW-1:0]  pw,
  input  logic [XLEN-1:0] crs1,
  input  logic [XLEN-1:0] crs2,
  output logic [XLEN-1:0] result
);
  p_mul_state_t r_state, w_state_nxt;
  logic [PWW-1:0] r_pw;
  logic r_mul_h, r_clmul;
  logic [6:0] r_cnt;
  logic [2*XLEN-1:0] r_acc, r_mcand, w_acc_nxt, w_mcand_lay;
  logic [XLEN-1:0] r_mplier, w_res;
  logic [PWW-1:0][2*XLEN-1:0] w_lay;
  logic [PWW-1:0][XLEN-1:0] w_sel;
  logic w_last, w_unused;
  assign w_unused = mul_l;
  if (!p_mul_xlen_ok(XLEN) || !p_mul_bps_ok(BPS)) begin : g_bad_cfg
    $error("p_mul_radix: XLEN must be 32 or 64 and BPS 1, 2 or 4");
  end
  // each lane's multiplicand sits zero-extended in its own 2W-bit field, matching the accumulator layout
  for (genvar k = 0; k < PWW; k++) begin : g_k
    localparam int W = XLEN >> k;
    for (genvar i = 0; i < XLEN / W; i++) begin : g_i
      assign w_lay[k][2*W*i +: 2*W] = {{W{1'b0}}, crs1[W*i +: W]};
      assign w_sel[k][W*i +: W] = r_mul_h ? r_acc[2*W*i+W +: W] : r_acc[2*W*i +: W];
    end
  end
  always_comb begin
    w_mcand_lay = '0;
    w_res = '0;
    w_last = r_cnt == 7'd0;
    for (int k = 0; k < PWW; k++) begin
      if (pw == (PWW'(1) << k)) w_mcand_lay = w_lay[k];
      if (r_pw == (PWW'(1) << k)) begin
        w_res = w_sel[k];
        w_last = r_cnt == 7'(p_mul_steps(XLEN, k, BPS) - 1);
      end
    end
  end
  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = r_state == IDLE ? (valid ? RUN : IDLE) :
                  r_state == RUN  ? (!valid ? IDLE : w_last ? DONE : RUN) : IDLE;
  end
  assign ready = r_state == DONE;
  assign result = ready ? w_res : '0;
  p_mul_step #(.XLEN(XLEN), .BPS(BPS), .PWW(PWW)) u_step (
    .i_acc(r_acc),
    .i_mcand(r_mcand),
    .i_mplier(r_mplier),
    .i_pw(r_pw),
    .i_clmul(r_clmul),
    .o_acc(w_acc_nxt)
  );
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) r_state <= IDLE;
    else r_state <= w_state_nxt;
  // operands shift globally; no lane ever consumes bits that crossed in from a neighbour
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      r_pw <= '0;
      r_mul_h <= 1'b0;
      r_clmul <= 1'b0;
      r_cnt <= '0;
      r_acc <= '0;
      r_mcand <= '0;
      r_mplier <= '0;
    end else if (r_state == IDLE && valid) begin
      r_pw <= pw;
      r_mul_h <= mul_h;
      r_clmul <= clmul;
      r_cnt <= '0;
      r_acc <= '0;
      r_mcand <= w_mcand_lay;
      r_mplier <= crs2;
    end else if (r_state == RUN) begin
      r_acc <= w_acc_nxt;
      r_mcand <= r_mcand << BPS;
      r_mplier <= r_mplier >> BPS;
      r_cnt <= r_cnt + 7'd1;
    end
endmodule

// File: tb/tb_p_mul_radix.sv
// tb_p_mul_radix: directed checks of the packed radix multiplier at BPS=1 and BPS=4
module tb_p_mul_radix;
  import p_mul_pkg::*;
  logic clk = 1'b0;
  logic resetn, valid, mul_l, mul_h, clmul;
  logic [4:0] pw;
  logic [31:0] crs1, crs2, a, b;
  logic ready1, ready4;
  logic [31:0] result1, result4;
  int checks = 0;
  int errors = 0;
  int lat, seen;
  always #5 clk = ~clk;
  p_mul_radix #(.XLEN(32), .BPS(1)) u_dut1 (
    .clock(clk), .resetn(resetn), .valid(valid), .ready(ready1), .mul_l(mul_l), .mul_h(mul_h),
    .clmul(clmul), .pw(pw), .crs1(crs1), .crs2(crs2), .result(result1)
  );
  p_mul_radix #(.XLEN(32), .BPS(4)) u_dut4 (
    .clock(clk), .resetn(resetn), .valid(valid), .ready(ready4), .mul_l(mul_l), .mul_h(mul_h),
    .clmul(clmul), .pw(pw), .crs1(crs1), .crs2(crs2), .result(result4)
  );
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] ref_mul(input logic [31:0] x_in, input logic [31:0] y_in,
                                          input int k, input bit h, input bit cl);
    int w;
    logic [63:0] m, x, y, p, lane;
    logic [31:0] r;
    w = 32 >> k;
    m = (64'd1 << w) - 64'd1;
    r = '0;
    for (int i = 0; i < 32 / w; i++) begin
      x = {32'd0, x_in >> (w * i)} & m;
      y = {32'd0, y_in >> (w * i)} & m;
      p = '0;
      if (cl) begin
        for (int j = 0; j < w; j++) if (y[j]) p = p ^ (x << j);
      end else p = x * y;
      lane = (h ? p >> w : p) & m;
      r = r | (lane[31:0] << (w * i));
    end
    return r;
  endfunction
  task automatic run_op(input bit sel4, input string tag, input logic [4:0] p, input bit h,
                        input bit l, input bit cl, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp_r, input int exp_lat);
    int n;
    logic [31:0] got;
    @(posedge clk); #1;
    pw = p; mul_h = h; mul_l = l; clmul = cl; crs1 = x; crs2 = y; valid = 1'b1;
    n = 0;
    got = '0;
    while (n < 100) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        crs1 = ~x; crs2 = y ^ 32'h5a5a5a5a; pw = ~p; mul_h = ~h; clmul = ~cl;
      end
      if (sel4 ? ready4 : ready1) begin
        got = sel4 ? result4 : result1;
        break;
      end
    end
    check({tag, "_lat"}, n, exp_lat);
    check({tag, "_res"}, got, exp_r);
    valid = 1'b0;
    @(posedge clk); #1;
    check({tag, "_pulse"}, sel4 ? ready4 : ready1, 0);
  endtask
  initial begin
    resetn = 1'b0; valid = 1'b0; mul_l = 1'b0; mul_h = 1'b0; clmul = 1'b0;
    pw = '0; crs1 = '0; crs2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready1", ready1, 0);
    check("rst_result1", result1, 0);
    check("rst_ready4", ready4, 0);
    check("rst_result4", result4, 0);
    check("rst_state1", u_dut1.r_state, IDLE);
    resetn = 1'b1;
    run_op(0, "w32_l", 5'b00001, 0, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33);
    run_op(0, "w32_h", 5'b00001, 1, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run_op(0, "w8_l", 5'b00100, 0, 1, 0, 32'h02030405, 32'h80FF1011, 32'h00FD4055, 9);
    run_op(0, "w8_h", 5'b00100, 1, 0, 0, 32'h02030405, 32'h80FF1011, 32'h01020000, 9);
    run_op(0, "w8_none", 5'b00100, 0, 0, 0, 32'h02030405, 32'h80FF1011, 32'h00FD4055, 9);
    run_op(0, "clmul_l", 5'b00001, 0, 1, 1, 32'h00000003, 32'h00000003, 32'h00000005, 33);
    run_op(0, "clmul_h", 5'b00001, 1, 0, 1, 32'h80000000, 32'h80000000, 32'h40000000, 33);
    run_op(0, "w2_l", 5'b10000, 0, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h55555555, 3);
    @(posedge clk); #1;
    pw = 5'b00001; mul_l = 1'b1; mul_h = 1'b0; clmul = 1'b0;
    crs1 = 32'h12345678; crs2 = 32'h9ABCDEF0; valid = 1'b1;
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (ready1) seen++;
    end
    valid = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready1) seen++;
    end
    check("abort_no_ready", seen, 0);
    run_op(0, "abort_next", 5'b00010, 0, 1, 0, 32'h00030002, 32'h00050007, 32'h000F000E, 17);
    for (int k = 0; k < 5; k++)
      for (int v = 0; v < 4; v++) begin
        a = $urandom;
        b = $urandom;
        run_op(1, $sformatf("sweep_k%0d_v%0d", k, v), 5'(1 << k), v[0], !v[0], v[1], a, b,
               ref_mul(a, b, k, v[0], v[1]), ((32 >> k) + 3) / 4 + 1);
      end
    run_op(1, "illegal_pw3", 5'b00011, 0, 1, 0, 32'h12345678, 32'h9ABCDEF0, 32'h0, 2);
    run_op(0, "illegal_pw0", 5'b00000, 1, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 2);
    @(posedge clk); #1;
    pw = 5'b00001; mul_l = 1'b1; mul_h = 1'b0; clmul = 1'b0;
    crs1 = 32'hFFFFFFFF; crs2 = 32'hFFFFFFFF; valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("midrun_state", u_dut1.r_state, RUN);
    resetn = 1'b0; valid = 1'b0;
    #1;
    check("midrun_rst_ready", ready1, 0);
    check("midrun_rst_result", result1, 0);
    check("midrun_rst_state", u_dut1.r_state, IDLE);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    check("post_rst_state", u_dut1.r_state, IDLE);
    check("post_rst_ready", ready1, 0);
    @(posedge clk); #1;
    pw = 5'b10000; mul_l = 1'b1; mul_h = 1'b0; clmul = 1'b0;
    crs1 = 32'hFFFFFFFF; crs2 = 32'hFFFFFFFF; valid = 1'b1;
    lat = 0;
    while (lat < 20 && !ready4) begin
      @(posedge clk); #1;
      lat++;
    end
    check("done_lat", lat, 2);
    check("done_res", result4, 32'h55555555);
    resetn = 1'b0; valid = 1'b0;
    #1;
    check("done_rst_ready", ready4, 0);
    check("done_rst_result", result4, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    run_op(0, "after_rst", 5'b00010, 0, 1, 0, 32'h00030002, 32'h00050007, 32'h000F000E, 17);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/p_mul_radix.md
# p_mul_radix

Parametrised, multi-cycle packed multiplier for the packed-arithmetic unit. It supports packed lanes from XLEN/1 down to 2 bits and both integer and carry-less products, low or high half. A configurable number of multiplier bits, BPS, is retired per cycle. Operands are captured at start, so the requester may change `crs1`/`crs2` while the operation runs. It replaces the fixed 32-bit, 1-bit-per-step packed multiplier in the execute stage behind the same valid/ready handshake.

## Interface
- `XLEN`, 32: datapath width; legal values 32 or 64.
- `BPS`, 1: multiplier bits consumed per step; legal values 1, 2 or 4.
- `PWW`, $clog2(XLEN): width of `pw`; derived, not overridden.
- `clock`  in  1  sole clock; all state on its rising edge.
- `resetn`  in  1  reset, asynchronous and active-low.
- `valid`  in  1  request; held high until `ready`.
- `ready`  out  1  one-cycle pulse; `result` is valid while it is high.
- `mul_l`  in  1  return the low W bits of each lane product.
- `mul_h`  in  1  return the high W bits of each lane product; takes priority over `mul_l`.
- `clmul`  in  1  carry-less (XOR) product instead of integer product.
- `pw`  in  PWW  one-hot pack width; bit k selects lane width W = XLEN>>k.
- `crs1`  in  XLEN  packed multiplicand.
- `crs2`  in  XLEN  packed multiplier.
- `result`  out  XLEN  packed result.

## Operation
- State machine: IDLE, RUN, DONE. Reset state is IDLE; `ready`=0, `result`=0, internal count and accumulators=0.
- IDLE with `valid`=1:
  - capture `crs1`, `crs2`, `pw`, `mul_h`, `clmul`;
  - clear the accumulators, count=0, go to RUN.
- IDLE with `valid`=0: stay in IDLE.
- RUN, per step, in every lane independently:
  - take the next min(BPS,W) multiplier bits, LSB first;
  - form the partial product of the lane multiplicand and those bits, shifted by count·BPS;
  - accumulate into a 2W-bit lane accumulator, by addition mod 2^2W, or by XOR when `clmul`=1.
- Carries never cross lane boundaries.
- Step count N = ceil(W/BPS). For example, W=2 with BPS=4 gives N=1.
- After N steps, go to DONE.
- DONE:
  - `ready`=1;
  - `result` lane = accumulator[2W-1:W] when `mul_h`=1, else accumulator[W-1:0];
  - next state is IDLE.
- `mul_l`=`mul_h`=0 is treated as `mul_l`.
- `clmul` with `mul_h` gives the high half of the carry-less product (clmulh). Bit 2W-1 of a carry-less product is always 0.
- Illegal `pw` (zero, or more than one bit set): one RUN step, then DONE with `result`=0.
- `valid` falls in RUN or DONE: go to IDLE at the next edge. `ready` is low from that edge, and no result is produced.
- `valid` still high in the IDLE cycle after DONE: a new operation starts using the operands present then. The requester must drop `valid` after `ready`.
- `resetn` low at any time: immediately forces IDLE, `ready`=0, `result`=0. Any operation in progress is lost.
- `result` is 0 whenever `ready`=0.

## Timing
- Cycle 0 is the first cycle in IDLE with `valid`=1.
- RUN occupies cycles 1..N; `ready` is high in cycle N+1.
- Latency examples:
  - XLEN=32, BPS=1, W=32: ready at cycle 33.
  - BPS=4, W=16: ready at cycle 5.
  - W=2, BPS=1: ready at cycle 3.
- `ready` is never high for two consecutive cycles.
- With back-to-back requests there is at least one IDLE cycle between operations.
- `ready` and `result` are driven from registered state only; there is no combinational path from any input.

## Structure
- Package `p_mul_pkg` holds:
  - the `pw` one-hot index constants;
  - state enum `p_mul_state_t` (IDLE/RUN/DONE);
  - function `p_mul_steps(xlen, k, bps)`, returning N;
  - the legality checks for XLEN and BPS, used in an elaboration-time assertion.
- Sub-module `p_mul_step` is combinational and has one instance. Inputs: accumulators, multiplicand, the current BPS multiplier bits per lane, `pw`, `clmul`. Output: the next accumulators. Lane masking and the add/XOR selection live here.
- The top level holds the FSM, step counter, operand registers and result selection.

## Test plan
- XLEN=32, BPS=1, pw=W32, `mul_l`, crs1=crs2=0xFFFFFFFF -> result 0x00000001 with ready at cycle 33; the same with `mul_h` -> 0xFFFFFFFE.
- pw=W8, crs1=0x02030405, crs2=0x80FF1011 -> `mul_l` gives 0x00FD4055, `mul_h` gives 0x01020000.
- `clmul`, pw=W32:
  - crs1=crs2=0x00000003 -> 0x00000005;
  - `clmul`+`mul_h`, crs1=crs2=0x80000000 -> 0x40000000.
- Abort:
  - drop `valid` at cycle 10 -> ready never asserts;
  - the next request (pw=W16, crs1=0x00030002, crs2=0x00050007, `mul_l`) -> 0x000F000E.
- Reset: assert `resetn`=0 mid-RUN -> `ready`/`result` are 0 immediately, and the FSM is in IDLE after release.
- BPS=4 sweep over all legal pw values with random operands, checked against a reference model:
  - latency equals ceil(W/4)+1;
  - an illegal pw of 0b00011 -> result 0 at cycle 2.
